// File: rtl/game_ctrl_pkg.sv
// Shared definitions for the brick-breaker game sequencer: state encoding and defaults.
package game_pkg;

  localparam int unsigned STATE_W        = 3;
  localparam int unsigned NUM_BRICKS_DEF = 6;
  localparam int unsigned LIVES_INIT_DEF = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE       = 3'd0,
    ST_SERVE_WAIT = 3'd1,
    ST_LAUNCH     = 3'd2,
    ST_PLAY       = 3'd3,
    ST_LOST       = 3'd4,
    ST_OVER       = 3'd5,
    ST_WIN        = 3'd6
  } state_e;

endpackage

// File: rtl/game_ctrl_if.sv
// Bundle of play-field events in and ball/HUD controls out of the game sequencer.
interface game_ctrl_if #(
  parameter int unsigned NUM_BRICKS = game_pkg::NUM_BRICKS_DEF,
  parameter int unsigned SCORE_W    = 8
);

  logic                         start_btn;
  logic                         ball_destroyed;
  logic                         hit_valid;
  logic [2:0]                   hit_idx;
  logic                         ball_rst_n;
  logic                         ball_start;
  logic [NUM_BRICKS-1:0]        bricks_exist;
  logic [SCORE_W-1:0]           score;
  logic [1:0]                   lives;
  logic [game_pkg::STATE_W-1:0] state;
  logic                         game_over;
  logic                         game_won;

  modport master (
    output start_btn, ball_destroyed, hit_valid, hit_idx,
    input  ball_rst_n, ball_start, bricks_exist, score, lives, state, game_over, game_won
  );

  modport slave (
    input  start_btn, ball_destroyed, hit_valid, hit_idx,
    output ball_rst_n, ball_start, bricks_exist, score, lives, state, game_over, game_won
  );

endinterface

// File: rtl/game_ctrl_serve_timer.sv
// Load/count pulse counter; tc_o is high on the last of TICKS counts and the count wraps.
module serve_timer #(
  parameter int unsigned TICKS = 50000000
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int unsigned CW = (TICKS > 1) ? $clog2(TICKS) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tc_o = (cnt_q == CW'(TICKS - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tc_o ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/game_ctrl.sv
// Game-level sequencer: serve timing, brick mask, score and lives for the ball datapath.
module game_ctrl
  import game_pkg::*;
#(
  parameter int unsigned NUM_BRICKS       = NUM_BRICKS_DEF,
  parameter int unsigned LIVES_INIT       = LIVES_INIT_DEF,
  parameter int unsigned SERVE_TICKS      = 50000000,
  parameter int unsigned SCORE_W          = 8,
  parameter int unsigned POINTS_PER_BRICK = 1
) (
  input  logic        clk,
  input  logic        rst,
  game_ctrl_if.slave  bus
);

  state_e                state_q, state_d;
  logic [NUM_BRICKS-1:0] bricks_q, bricks_d, clr_mask;
  logic [SCORE_W-1:0]    score_q, score_d;
  logic [SCORE_W:0]      score_sum;
  logic [1:0]            lives_q, lives_d;
  logic                  start_q, start_rise;
  logic                  ball_rst_n_q, ball_rst_n_d;
  logic                  ball_start_q, ball_start_d;
  logic                  over_q, over_d;
  logic                  won_q, won_d;
  logic                  entering_serve;
  logic                  tmr_tc;

  assign start_rise = bus.start_btn & ~start_q;

  always_comb begin
    clr_mask = '0;
    for (int unsigned i = 0; i < NUM_BRICKS; i++) begin
      if (bus.hit_valid && bus.hit_idx == 3'(i) && bricks_q[i]) clr_mask[i] = 1'b1;
    end
  end

  assign score_sum = {1'b0, score_q} + (SCORE_W+1)'(POINTS_PER_BRICK);

  always_comb begin
    state_d  = state_q;
    bricks_d = bricks_q;
    score_d  = score_q;
    lives_d  = lives_q;
    unique case (state_q)
      ST_IDLE:       if (start_rise) state_d = ST_SERVE_WAIT;
      ST_SERVE_WAIT: if (tmr_tc) state_d = ST_LAUNCH;
      ST_LAUNCH:     state_d = ST_PLAY;
      ST_PLAY: begin
        // The hit is applied first so a same-cycle loss still keeps the point,
        // and clearing the last brick beats a same-cycle loss.
        if (|clr_mask) begin
          bricks_d = bricks_q & ~clr_mask;
          score_d  = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
        end
        if ((|clr_mask) && (bricks_d == '0)) state_d = ST_WIN;
        else if (bus.ball_destroyed)         state_d = ST_LOST;
      end
      ST_LOST: begin
        if (lives_q <= 2'd1) begin
          lives_d = '0;
          state_d = ST_OVER;
        end else begin
          lives_d = lives_q - 2'd1;
          state_d = ST_SERVE_WAIT;
        end
      end
      ST_OVER, ST_WIN: begin
        if (start_rise) begin
          bricks_d = '1;
          score_d  = '0;
          lives_d  = 2'(LIVES_INIT);
          state_d  = ST_SERVE_WAIT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  assign entering_serve = (state_d == ST_SERVE_WAIT) && (state_q != ST_SERVE_WAIT);

  always_comb begin
    ball_start_d = (state_d == ST_LAUNCH);
    over_d       = (state_d == ST_OVER);
    won_d        = (state_d == ST_WIN);
    ball_rst_n_d = !((state_d == ST_IDLE) || (state_d == ST_OVER) ||
                     (state_d == ST_WIN)  || entering_serve);
  end

  serve_timer #(.TICKS(SERVE_TICKS)) u_serve_timer (
    .clk    (clk),
    .rst    (rst),
    .load_i (entering_serve),
    .en_i   (state_q == ST_SERVE_WAIT),
    .tc_o   (tmr_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      bricks_q     <= '1;
      score_q      <= '0;
      lives_q      <= 2'(LIVES_INIT);
      start_q      <= 1'b0;
      ball_rst_n_q <= 1'b0;
      ball_start_q <= 1'b0;
      over_q       <= 1'b0;
      won_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      bricks_q     <= bricks_d;
      score_q      <= score_d;
      lives_q      <= lives_d;
      start_q      <= bus.start_btn;
      ball_rst_n_q <= ball_rst_n_d;
      ball_start_q <= ball_start_d;
      over_q       <= over_d;
      won_q        <= won_d;
    end
  end

  assign bus.state        = state_q;
  assign bus.bricks_exist = bricks_q;
  assign bus.score        = score_q;
  assign bus.lives        = lives_q;
  assign bus.ball_rst_n   = ball_rst_n_q;
  assign bus.ball_start   = ball_start_q;
  assign bus.game_over    = over_q;
  assign bus.game_won     = won_q;

endmodule

// File: doc/game_ctrl.md
Name: game_ctrl

Overview:
Game-level sequencer for the ball datapath in the brick-breaker design. It owns the brick-existence mask, score and lives. It drives the ball's active-low reset and start inputs, times the serve delay, and consumes brick-hit and ball-lost events from the play field. It sits between the top-level button logic and the ball, paddle and brick renderers.

Parameters:
NUM_BRICKS, 6, number of bricks tracked (bit i of bricks_exist = brick i+1)
LIVES_INIT, 3, lives loaded at game start (1..3)
SERVE_TICKS, 50000000, clk cycles spent in SERVE_WAIT before launch (>=2)
SCORE_W, 8, score width
POINTS_PER_BRICK, 1, score increment per brick cleared

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
start_btn  in  1  start/restart request, already synchronised; level
ball_destroyed  in  1  ball "destroyed" flag (ball fell below paddle)
hit_valid  in  1  one-cycle strobe: ball collided with a brick
hit_idx  in  3  index 0..NUM_BRICKS-1 of the brick hit, qualified by hit_valid
ball_rst_n  out  1  active-low reset to the ball block
ball_start  out  1  launch pulse to the ball block
bricks_exist  out  NUM_BRICKS  live-brick mask, fed back to ball and renderer
score  out  SCORE_W  bricks cleared times POINTS_PER_BRICK
lives  out  2  remaining lives
state  out  3  current FSM state (debug/HUD)
game_over  out  1  high while in OVER
game_won  out  1  high while in WIN

Behaviour:
- Reset (rst=1 at a clk edge) sets: state=IDLE, bricks_exist=all ones, score=0, lives=LIVES_INIT, ball_rst_n=0, ball_start=0, game_over=0, game_won=0, serve counter=0, start edge register=0.
- A reset mid-game aborts immediately, regardless of state. Pending hit/destroyed inputs in that cycle are ignored.
- start_btn is edge-detected with a registered previous value. start_rise = start_btn & ~start_q. Held levels do not retrigger.
- FSM states and encoding: IDLE=0, SERVE_WAIT=1, LAUNCH=2, PLAY=3, LOST=4, OVER=5, WIN=6. Encoding 7 is illegal and goes to IDLE next cycle.
- IDLE: ball_rst_n=0. start_rise -> SERVE_WAIT.
- SERVE_WAIT:
  - ball_rst_n=0 for the first cycle (ball re-centres at 309,435), then 1.
  - Counter counts 0..SERVE_TICKS-1; at terminal count -> LAUNCH.
  - Hits and destroyed are ignored.
- LAUNCH: ball_start=1 for exactly this one cycle. -> PLAY.
- PLAY, ball_rst_n=1:
  - Brick hit: hit_valid with hit_idx<NUM_BRICKS and bricks_exist[hit_idx]=1 clears that bit and adds POINTS_PER_BRICK to score.
  - Score saturates at all ones.
  - Out-of-range index or already-cleared brick: no effect.
  - Mask becomes zero after the clear -> WIN. WIN has priority over a same-cycle ball_destroyed.
  - Otherwise ball_destroyed=1 -> LOST. A hit in the same cycle is still applied first.
- LOST (one cycle): lives decrements.
  - Old lives==1 -> OVER (lives=0).
  - Otherwise -> SERVE_WAIT with a fresh ball reset pulse. Bricks and score are kept.
- OVER / WIN: flag high; ball_rst_n=0 (ball frozen at start). start_rise reloads bricks, score and lives, then -> SERVE_WAIT.
- All outputs are registered. Latency from an input event to an output change is 1 cycle.
- Serve counter width is clog2(SERVE_TICKS). The counter clears on every entry to SERVE_WAIT.

Decomposition:
- Package game_pkg: state encoding constants, NUM_BRICKS default, LIVES_INIT default, and state width.
- One natural sub-module, serve_timer: a load/count/terminal-count pulse counter parameterised by SERVE_TICKS. The same timer is reused for the ball movement tick.
- Edge detect stays inline.

Test Plan:
1. Reset, then start_btn rise with SERVE_TICKS=4 -> ball_rst_n low 1 cycle, LAUNCH after 4 cycles in SERVE_WAIT, ball_start high exactly 1 cycle, state=3.
2. In PLAY, hit_valid with idx 2, then idx 2 again, then idx 7 -> bricks_exist 111111->111011, unchanged, unchanged; score 0->1->1->1.
3. Clear all 6 bricks, with the last hit coincident with ball_destroyed=1 -> state=WIN, game_won=1, score=6, lives unchanged at 3.
4. ball_destroyed three times, each followed by a serve -> lives 3->2->1->0. The first two losses return to SERVE_WAIT with bricks preserved; the third gives OVER, game_over=1.
5. In OVER, hold start_btn high across many cycles -> exactly one restart. bricks_exist=111111, score=0, lives=3, state=SERVE_WAIT.
6. Assert rst mid-PLAY with hit_valid=1 that cycle -> next cycle state=IDLE, mask all ones, score=0, ball_rst_n=0.
